alu_rr_sequencer: RTL and testbench



---
 rtl/alu_rr_if.sv | 18 +
 rtl/alu_rr_sequencer.sv | 72 +++++++
 tb/tb_alu_rr_sequencer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_rr_if.sv
// alu_rr_if: request, ALU drive and response signal bundle for alu_rr_sequencer
// slave  : sequencer side (drives req*_ready, alu_opcode/a/b, rsp_*)
// master : requesters, ALU and response consumer (drive req*_valid/op/a/b, alu_y, rsp_ready)
interface alu_rr_if #(parameter int W = 3);
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0] req0_op, req0_a, req0_b, req1_op, req1_a, req1_b;
  logic [W-1:0] alu_opcode, alu_a, alu_b, alu_y;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_z, rsp_n, rsp_err;
  logic [W-1:0] rsp_y;
  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, req1_valid, req1_op, req1_a, req1_b, alu_y, rsp_ready,
    output req0_ready, req1_ready, alu_opcode, alu_a, alu_b, rsp_valid, rsp_id, rsp_y, rsp_z, rsp_n, rsp_err
  );
  modport master (
    output req0_valid, req0_op, req0_a, req0_b, req1_valid, req1_op, req1_a, req1_b, alu_y, rsp_ready,
    input  req0_ready, req1_ready, alu_opcode, alu_a, alu_b, rsp_valid, rsp_id, rsp_y, rsp_z, rsp_n, rsp_err
  );
endinterface

// File: rtl/alu_rr_sequencer.sv
// alu_rr_sequencer: two-requester round-robin front end for a shared alu
// clk, rst_n : clock, async active-low reset
// bus        : alu_rr_if.slave (request channels, registered alu drive, tagged response channel)
module alu_rr_sequencer #(parameter int W = 3) (
  input logic     clk,
  input logic     rst_n,
  alu_rr_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t       state_q, state_d;
  logic         rr_q, id_q, gnt1, hs, err;
  logic         rsp_valid_q, rsp_id_q, rsp_z_q, rsp_n_q, rsp_err_q;
  logic [W-1:0] alu_opcode_q, alu_a_q, alu_b_q, rsp_y_q, y;
  // rr_q names the requester that wins a tie
  assign gnt1 = bus.req1_valid && (!bus.req0_valid || rr_q);
  assign hs   = (state_q == IDLE) && (bus.req0_valid || bus.req1_valid);
  // codes above XOR are unassigned; their result is forced to zero
  assign err  = alu_opcode_q > W'(6);
  assign y    = err ? '0 : bus.alu_y;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  always_comb
    state_d = (state_q == IDLE) ? (hs ? EXEC : IDLE) :
              (state_q == EXEC) ? RESP :
              (bus.rsp_ready ? IDLE : RESP);
  always_comb begin
    bus.req0_ready = rst_n && hs && !gnt1;
    bus.req1_ready = rst_n && hs && gnt1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rr_q         <= 1'b0;
      id_q         <= 1'b0;
      alu_opcode_q <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_y_q      <= '0;
      rsp_z_q      <= 1'b0;
      rsp_n_q      <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      if (hs) begin
        rr_q         <= !gnt1;
        id_q         <= gnt1;
        alu_opcode_q <= gnt1 ? bus.req1_op : bus.req0_op;
        alu_a_q      <= gnt1 ? bus.req1_a : bus.req0_a;
        alu_b_q      <= gnt1 ? bus.req1_b : bus.req0_b;
      end
      if (state_q == EXEC) begin
        rsp_valid_q <= 1'b1;
        rsp_id_q    <= id_q;
        rsp_y_q     <= y;
        rsp_z_q     <= (y == '0);
        rsp_n_q     <= y[W-1];
        rsp_err_q   <= err;
      end else if (state_q == RESP && bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  assign bus.alu_opcode = alu_opcode_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_y      = rsp_y_q;
  assign bus.rsp_z      = rsp_z_q;
  assign bus.rsp_n      = rsp_n_q;
  assign bus.rsp_err    = rsp_err_q;
endmodule

// File: tb/tb_alu_rr_sequencer.sv
// tb_alu_rr_sequencer: directed and randomized checks of alu_rr_sequencer with a behavioural alu
module tb_alu_rr_sequencer;
  localparam int W = 3;
  localparam logic [2:0] LL = 3'd0, LR = 3'd1, AR = 3'd2, NOT_ = 3'd3, AND_ = 3'd4, OR_ = 3'd5, XOR_ = 3'd6, BAD = 3'd7;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int passed = 0;
  alu_rr_if #(.W(W)) bus();
  alu_rr_sequencer #(.W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [2:0] ref_alu(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b);
    case (op)
      LL:      return a << b;
      LR:      return a >> b;
      AR:      return 3'($signed(a) >>> b);
      NOT_:    return ~a;
      AND_:    return a & b;
      OR_:     return a | b;
      XOR_:    return a ^ b;
      default: return 3'd0;
    endcase
  endfunction
  assign bus.alu_y = ref_alu(bus.alu_opcode, bus.alu_a, bus.alu_b);
  task automatic idle_inputs();
    bus.req0_valid = 0; bus.req0_op = 0; bus.req0_a = 0; bus.req0_b = 0;
    bus.req1_valid = 0; bus.req1_op = 0; bus.req1_a = 0; bus.req1_b = 0;
    bus.rsp_ready = 0;
  endtask
  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask
  task automatic drive(input bit id, input bit v, input logic [2:0] op, input logic [2:0] a, input logic [2:0] b);
    if (id) begin bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; end
    else    begin bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; end
  endtask
  // raise valid at a negedge, hold until the handshake edge, return #1 after it
  task automatic issue(input bit id, input logic [2:0] op, input logic [2:0] a, input logic [2:0] b, output bit ok);
    ok = 0;
    @(negedge clk);
    drive(id, 1, op, a, b);
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      ok = id ? bus.req1_ready : bus.req0_ready;
      @(posedge clk);
      if (!ok) @(negedge clk);
    end
    #1;
    drive(id, 0, op, a, b);
  endtask
  task automatic wait_rsp(output bit ok);
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      ok = bus.rsp_valid;
    end
  endtask
  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    bus.req0_valid = 1; bus.req1_valid = 1;
    #2;
    checks++; if ({bus.alu_opcode, bus.alu_a, bus.alu_b, bus.rsp_valid, bus.rsp_id, bus.rsp_y, bus.rsp_z, bus.rsp_n, bus.rsp_err} !== 15'd0) $display("FAIL reset_outputs got=%h exp=0", {bus.alu_opcode, bus.alu_a, bus.alu_b, bus.rsp_valid, bus.rsp_id, bus.rsp_y, bus.rsp_z, bus.rsp_n, bus.rsp_err}); else passed++;
    checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) $display("FAIL reset_ready got=%b exp=00", {bus.req0_ready, bus.req1_ready}); else passed++;
    do_reset();
  endtask
  task automatic test_single_and();
    bit ok;
    do_reset();
    bus.rsp_ready = 1;
    issue(0, AND_, 3'b110, 3'b011, ok);
    checks++; if (ok !== 1'b1) $display("FAIL and_handshake got=%0b exp=1", ok); else passed++;
    checks++; if ({bus.alu_opcode, bus.alu_a, bus.alu_b} !== {AND_, 3'b110, 3'b011}) $display("FAIL and_alu_drive got=%b exp=%b", {bus.alu_opcode, bus.alu_a, bus.alu_b}, {AND_, 3'b110, 3'b011}); else passed++;
    @(negedge clk);
    checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL and_exec_valid got=%0b exp=0", bus.rsp_valid); else passed++;
    @(negedge clk);
    checks++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_y, bus.rsp_z, bus.rsp_n, bus.rsp_err} !== {1'b1, 1'b0, 3'b010, 3'b000}) $display("FAIL and_rsp got=%b exp=%b", {bus.rsp_valid, bus.rsp_id, bus.rsp_y, bus.rsp_z, bus.rsp_n, bus.rsp_err}, {1'b1, 1'b0, 3'b010, 3'b000}); else passed++;
    @(negedge clk);
    checks++; if ({bus.rsp_valid, bus.rsp_y} !== {1'b0, 3'b010}) $display("FAIL and_after_hs got=%b exp=0010", {bus.rsp_valid, bus.rsp_y}); else passed++;
  endtask
  task automatic test_fairness();
    bit ids[$];
    logic [2:0] ys[$];
    bit ns[$];
    bit last = 1;
    do_reset();
    bus.rsp_ready = 1;
    @(negedge clk);
    drive(0, 1, OR_, 3'b001, 3'b010);
    drive(1, 1, NOT_, 3'b011, 3'b000);
    for (int i = 0; i < 40 && ids.size() < 4; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin ids.push_back(bus.rsp_id); ys.push_back(bus.rsp_y); ns.push_back(bus.rsp_n); end
    end
    idle_inputs();
    checks++; if (ids.size() !== 4) $display("FAIL fair_count got=%0d exp=4", ids.size()); else passed++;
    for (int i = 0; i < ids.size(); i++) begin
      bit eid = !last;
      logic [2:0] ey = eid ? ref_alu(NOT_, 3'b011, 3'b000) : ref_alu(OR_, 3'b001, 3'b010);
      last = eid;
      checks++; if ({ids[i], ys[i], ns[i]} !== {eid, ey, ey[2]}) $display("FAIL fair_rsp%0d got=%b exp=%b", i, {ids[i], ys[i], ns[i]}, {eid, ey, ey[2]}); else passed++;
    end
  endtask
  task automatic test_backpressure();
    bit ok;
    logic [6:0] snap;
    do_reset();
    issue(1, XOR_, 3'b101, 3'b101, ok);
    checks++; if (ok !== 1'b1) $display("FAIL bp_handshake got=%0b exp=1", ok); else passed++;
    drive(0, 1, OR_, 3'b111, 3'b000);
    drive(1, 1, AND_, 3'b111, 3'b111);
    wait_rsp(ok);
    snap = {bus.rsp_id, bus.rsp_y, bus.rsp_z, bus.rsp_n, bus.rsp_err};
    checks++; if ({ok, snap} !== {1'b1, 1'b1, 3'b000, 3'b100}) $display("FAIL bp_rsp got=%b exp=%b", {ok, snap}, {1'b1, 1'b1, 3'b000, 3'b100}); else passed++;
    repeat (5) begin
      @(negedge clk); #1;
      checks++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_y, bus.rsp_z, bus.rsp_n, bus.rsp_err, bus.req0_ready, bus.req1_ready} !== {1'b1, snap, 2'b00}) $display("FAIL bp_hold got=%b exp=%b", {bus.rsp_valid, bus.rsp_id, bus.rsp_y, bus.rsp_z, bus.rsp_n, bus.rsp_err, bus.req0_ready, bus.req1_ready}, {1'b1, snap, 2'b00}); else passed++;
    end
    bus.rsp_ready = 1;
    #1;
    checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) $display("FAIL bp_release_ready got=%b exp=00", {bus.req0_ready, bus.req1_ready}); else passed++;
    @(negedge clk); #1;
    checks++; if ({bus.rsp_valid, bus.rsp_id, bus.req0_ready, bus.req1_ready} !== 4'b0110) $display("FAIL bp_after_hs got=%b exp=0110", {bus.rsp_valid, bus.rsp_id, bus.req0_ready, bus.req1_ready}); else passed++;
    idle_inputs();
  endtask
  task automatic test_illegal();
    bit ok;
    do_reset();
    bus.rsp_ready = 1;
    issue(0, BAD, 3'b111, 3'($urandom), ok);
    wait_rsp(ok);
    checks++; if ({ok, bus.rsp_err, bus.rsp_y, bus.rsp_z, bus.rsp_n} !== {2'b11, 3'b000, 2'b10}) $display("FAIL illegal_rsp got=%b exp=%b", {ok, bus.rsp_err, bus.rsp_y, bus.rsp_z, bus.rsp_n}, {2'b11, 3'b000, 2'b10}); else passed++;
    issue(0, OR_, 3'b001, 3'b100, ok);
    wait_rsp(ok);
    checks++; if ({ok, bus.rsp_err, bus.rsp_y, bus.rsp_z, bus.rsp_n} !== {2'b10, 3'b101, 2'b01}) $display("FAIL legal_after_illegal got=%b exp=%b", {ok, bus.rsp_err, bus.rsp_y, bus.rsp_z, bus.rsp_n}, {2'b10, 3'b101, 2'b01}); else passed++;
  endtask
  task automatic test_reset_mid();
    bit ok;
    do_reset();
    bus.rsp_ready = 1;
    issue(0, AND_, 3'b111, 3'b111, ok);
    drive(0, 1, OR_, 3'b001, 3'b001);
    drive(1, 1, NOT_, 3'b000, 3'b000);
    #1 rst_n = 0;
    #1;
    checks++; if ({bus.alu_opcode, bus.alu_a, bus.alu_b, bus.rsp_valid, bus.rsp_id, bus.rsp_y, bus.rsp_z, bus.rsp_n, bus.rsp_err, bus.req0_ready, bus.req1_ready} !== 17'd0) $display("FAIL mid_reset_outputs got=%h exp=0", {bus.alu_opcode, bus.alu_a, bus.alu_b, bus.rsp_valid, bus.rsp_id, bus.rsp_y, bus.rsp_z, bus.rsp_n, bus.rsp_err, bus.req0_ready, bus.req1_ready}); else passed++;
    @(negedge clk);
    rst_n = 1;
    #1;
    checks++; if ({bus.rsp_valid, bus.req0_ready, bus.req1_ready} !== 3'b010) $display("FAIL mid_reset_grant got=%b exp=010", {bus.rsp_valid, bus.req0_ready, bus.req1_ready}); else passed++;
    @(negedge clk);
    checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL mid_reset_no_rsp got=%0b exp=0", bus.rsp_valid); else passed++;
    idle_inputs();
  endtask
  task automatic test_shifts();
    bit ok;
    do_reset();
    bus.rsp_ready = 1;
    issue(0, LL, 3'b011, 3'b001, ok);
    checks++; if ({ok, bus.alu_opcode, bus.alu_a, bus.alu_b} !== {1'b1, LL, 3'b011, 3'b001}) $display("FAIL ll_drive got=%b exp=%b", {ok, bus.alu_opcode, bus.alu_a, bus.alu_b}, {1'b1, LL, 3'b011, 3'b001}); else passed++;
    wait_rsp(ok);
    checks++; if ({ok, bus.alu_opcode, bus.alu_a, bus.alu_b, bus.rsp_y, bus.rsp_n} !== {1'b1, LL, 3'b011, 3'b001, 3'b110, 1'b1}) $display("FAIL ll_rsp got=%b exp=%b", {ok, bus.alu_opcode, bus.alu_a, bus.alu_b, bus.rsp_y, bus.rsp_n}, {1'b1, LL, 3'b011, 3'b001, 3'b110, 1'b1}); else passed++;
    issue(1, AR, 3'b100, 3'b001, ok);
    checks++; if ({ok, bus.alu_opcode, bus.alu_a, bus.alu_b} !== {1'b1, AR, 3'b100, 3'b001}) $display("FAIL ar_drive got=%b exp=%b", {ok, bus.alu_opcode, bus.alu_a, bus.alu_b}, {1'b1, AR, 3'b100, 3'b001}); else passed++;
    wait_rsp(ok);
    checks++; if ({ok, bus.alu_opcode, bus.alu_a, bus.alu_b, bus.rsp_id, bus.rsp_y} !== {1'b1, AR, 3'b100, 3'b001, 1'b1, 3'b110}) $display("FAIL ar_rsp got=%b exp=%b", {ok, bus.alu_opcode, bus.alu_a, bus.alu_b, bus.rsp_id, bus.rsp_y}, {1'b1, AR, 3'b100, 3'b001, 1'b1, 3'b110}); else passed++;
  endtask
  // transaction-level model: one op in flight, response one edge after grant,
  // response retired on rsp_ready, ties go to whoever was not granted last
  task automatic test_random();
    bit busy = 0, up = 0, last = 1, g, win, v0, v1, rdy, eid, eerr;
    logic [2:0] op0, a0, b0, op1, a1, b1, eop, ea, eb, ey;
    do_reset();
    repeat (400) begin
      @(negedge clk);
      checks++; if (bus.rsp_valid !== (busy && up)) $display("FAIL rnd_rsp_valid got=%0b exp=%0b", bus.rsp_valid, busy && up); else passed++;
      if (busy && up) begin
        checks++; if ({bus.rsp_id, bus.rsp_y, bus.rsp_z, bus.rsp_n, bus.rsp_err} !== {eid, ey, ey == 3'd0, ey[2], eerr}) $display("FAIL rnd_rsp got=%b exp=%b", {bus.rsp_id, bus.rsp_y, bus.rsp_z, bus.rsp_n, bus.rsp_err}, {eid, ey, ey == 3'd0, ey[2], eerr}); else passed++;
      end
      if (busy) begin
        checks++; if ({bus.alu_opcode, bus.alu_a, bus.alu_b} !== {eop, ea, eb}) $display("FAIL rnd_alu_drive got=%b exp=%b", {bus.alu_opcode, bus.alu_a, bus.alu_b}, {eop, ea, eb}); else passed++;
      end
      v0 = ($urandom % 3) != 0; v1 = ($urandom % 3) != 0; rdy = ($urandom % 2) != 0;
      op0 = 3'($urandom); a0 = 3'($urandom); b0 = 3'($urandom);
      op1 = 3'($urandom); a1 = 3'($urandom); b1 = 3'($urandom);
      drive(0, v0, op0, a0, b0);
      drive(1, v1, op1, a1, b1);
      bus.rsp_ready = rdy;
      #1;
      g = !busy && (v0 || v1);
      win = (v0 && v1) ? !last : v1;
      checks++; if ({bus.req0_ready, bus.req1_ready} !== {g && !win, g && win}) $display("FAIL rnd_ready got=%b exp=%b", {bus.req0_ready, bus.req1_ready}, {g && !win, g && win}); else passed++;
      @(posedge clk);
      if (busy) begin
        if (!up) up = 1;
        else if (rdy) busy = 0;
      end else if (g) begin
        busy = 1; up = 0; last = win; eid = win;
        eop = win ? op1 : op0; ea = win ? a1 : a0; eb = win ? b1 : b0;
        eerr = (eop == BAD);
        ey = eerr ? 3'd0 : ref_alu(eop, ea, eb);
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d passed=%0d", checks, passed);
    $fatal(1);
  end
  initial begin
    test_reset();
    test_single_and();
    test_fairness();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    test_shifts();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
